game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level run controller for the jump game. It sequences the player and obstacle datapaths through attract, run, hit-freeze and game-over phases. It also generates the shared 1 ms movement tick, detects player/obstacle rectangle collisions, and keeps score and lives. It sits between the buttons and the player/obstacle movers, and drives their reset/enable inputs.

Parameters:
TICK_DIV, 50000, clk cycles per tick_1ms pulse (50 MHz -> 1 ms); must be >= 2
PLAYER_W, 50, player sprite width in pixels
PLAYER_H, 50, player sprite height in pixels
OBST_W, 30, obstacle width in pixels
OBST_H, 40, obstacle height in pixels
HIT_FREEZE, 500, ticks the game is frozen after a non-fatal hit
LIVES, 3, lives loaded at game start (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_btn  in  1  raw start button, active-high, asynchronous
jump_btn  in  1  raw jump button, active-high, asynchronous
x_player  in  16  player left edge, pixels
y_player  in  16  player top edge, pixels
x_obst  in  16  obstacle left edge, pixels
y_obst  in  16  obstacle top edge, pixels
tick_1ms  out  1  one-clk pulse every TICK_DIV cycles
player_rst  out  1  holds the player mover at ground/home
player_jump  out  1  synchronized jump request to the player mover
obst_en  out  1  obstacle mover enable
obst_respawn  out  1  one-clk pulse: obstacle returns to its spawn point
hit  out  1  one-clk pulse on every collision
score  out  16  ticks survived in RUN, saturating
lives  out  2  lives remaining
game_state  out  2  0=IDLE 1=RUN 2=HIT 3=OVER

Behaviour:
- Reset (async assert, sync release): state IDLE; tick counter 0; tick_1ms 0; score 0; lives=LIVES; player_rst 1; player_jump 0; obst_en 0; obst_respawn 0; hit 0; freeze counter 0; synchronizers cleared.
- start_btn and jump_btn each pass through a 2-flop synchronizer. start_pulse is the rising edge of synchronized start (one clk).
- Tick: counter runs 0..TICK_DIV-1 in every state. tick_1ms=1 on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
- Collision: compute overlap combinationally in 17-bit unsigned arithmetic so there is no wrap: xp<xo+OBST_W && xo<xp+PLAYER_W && yp<yo+OBST_H && yo<yp+PLAYER_H. Edges that only touch do not collide. Register the result as coll_q; all actions use coll_q (1-clk latency).
- Outputs by state:
  - IDLE: player_rst=1, obst_en=0.
  - RUN: player_rst=0, obst_en=1, player_jump=synchronized jump_btn.
  - HIT and OVER: player_rst=1, obst_en=0, player_jump=0.
- Transitions:
  - IDLE: start_pulse -> RUN; score<=0, lives<=LIVES, obst_respawn pulse.
  - RUN, coll_q=1: hit pulse, obst_respawn pulse, lives<=lives-1. If lives was 1 -> OVER (lives=0). Otherwise -> HIT with freeze<=HIT_FREEZE.
  - RUN, coll_q=0: score<=score+1 on tick_1ms, saturating at 0xFFFF.
  - HIT: freeze decrements on tick_1ms. When freeze==1 and tick_1ms fires -> RUN. coll_q is ignored in HIT.
  - OVER: score and lives hold. start_pulse -> IDLE (a second press starts a new game).
- Simultaneous tick_1ms and coll_q in RUN: the collision wins and score does not increment that cycle.
- start_pulse in RUN or HIT is ignored. A held button gives only one start_pulse.
- While coll_q stays 1 across consecutive cycles, only one hit is taken because the state leaves RUN on the first hit.
- Reset mid-game: immediate return to reset values; no pulse outputs are emitted.

Test Plan:
- Reset, TICK_DIV=4: tick_1ms high on cycles 3, 7, 11 after release; game_state=0; player_rst=1; lives=3.
- IDLE, pulse start_btn: within 3 clk game_state=1, obst_respawn one-clk pulse, score increments once per tick, player_jump follows jump_btn after 2 clk.
- RUN, player (300,400), obstacle (340,420) -> overlap: one clk later hit and obst_respawn pulse, lives 3->2, state HIT. With HIT_FREEZE=5, state returns to RUN after exactly 5 ticks. Score unchanged while in HIT.
- Touching edges, player (300,400), obstacle (350,420): no hit. Obstacle at (349,420): hit.
- Three hits: lives reach 0, state OVER, score frozen. start_btn -> IDLE. start_btn again -> RUN with score 0 and lives 3.
- Score preloaded at 0xFFFE in RUN, 3 ticks: score reads 0xFFFF and stays there. Assert reset mid-HIT: all outputs return to reset values.

Source files
------------

// File: rtl/game_sequencer.sv
// Run controller for the jump game: sequences IDLE/RUN/HIT/OVER, generates the shared
// 1 ms tick, detects player/obstacle overlap, and keeps score and lives.
module game_sequencer #(
    parameter int TICK_DIV   = 50000,
    parameter int PLAYER_W   = 50,
    parameter int PLAYER_H   = 50,
    parameter int OBST_W     = 30,
    parameter int OBST_H     = 40,
    parameter int HIT_FREEZE = 500,
    parameter int LIVES      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        jump_btn,
    input  logic [15:0] x_player,
    input  logic [15:0] y_player,
    input  logic [15:0] x_obst,
    input  logic [15:0] y_obst,
    output logic        tick_1ms,
    output logic        player_rst,
    output logic        player_jump,
    output logic        obst_en,
    output logic        obst_respawn,
    output logic        hit,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  game_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int CW = $clog2(TICK_DIV);
    localparam int FW = $clog2(HIT_FREEZE + 1);

    state_t          state, state_next;
    logic [CW-1:0]   tick_cnt;
    logic [FW-1:0]   freeze;
    logic [15:0]     score_q;
    logic [1:0]      lives_q;
    logic            start_meta, start_sync, start_prev;
    logic            jump_meta, jump_sync;
    logic            start_pulse, coll, coll_q;
    logic            score_clr, score_inc, lives_load, lives_dec, freeze_load, freeze_dec;
    logic [16:0]     xp, yp, xo, yo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            jump_meta  <= 1'b0;
            jump_sync  <= 1'b0;
        end else begin
            start_meta <= start_btn;
            start_sync <= start_meta;
            start_prev <= start_sync;
            jump_meta  <= jump_btn;
            jump_sync  <= jump_meta;
        end
    end

    assign start_pulse = start_sync & ~start_prev;
    assign tick_1ms    = (tick_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        tick_cnt <= '0;
        else if (tick_1ms) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + CW'(1);
    end

    // 17-bit compares so a sprite near the right/bottom edge cannot wrap past zero
    assign xp   = {1'b0, x_player};
    assign yp   = {1'b0, y_player};
    assign xo   = {1'b0, x_obst};
    assign yo   = {1'b0, y_obst};
    assign coll = (xp < xo + 17'(OBST_W))   && (xo < xp + 17'(PLAYER_W)) &&
                  (yp < yo + 17'(OBST_H))   && (yo < yp + 17'(PLAYER_H));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            coll_q  <= 1'b0;
            score_q <= '0;
            lives_q <= 2'(LIVES);
            freeze  <= '0;
        end else begin
            state  <= state_next;
            coll_q <= coll;
            if (score_clr)
                score_q <= '0;
            else if (score_inc && score_q != 16'hFFFF)
                score_q <= score_q + 16'd1;
            if (lives_load)
                lives_q <= 2'(LIVES);
            else if (lives_dec)
                lives_q <= lives_q - 2'd1;
            if (freeze_load)
                freeze <= FW'(HIT_FREEZE);
            else if (freeze_dec)
                freeze <= freeze - FW'(1);
        end
    end

    always_comb begin
        state_next   = state;
        player_rst   = 1'b1;
        obst_en      = 1'b0;
        player_jump  = 1'b0;
        obst_respawn = 1'b0;
        hit          = 1'b0;
        score_clr    = 1'b0;
        score_inc    = 1'b0;
        lives_load   = 1'b0;
        lives_dec    = 1'b0;
        freeze_load  = 1'b0;
        freeze_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    state_next   = RUN;
                    score_clr    = 1'b1;
                    lives_load   = 1'b1;
                    obst_respawn = 1'b1;
                end
            end
            RUN: begin
                player_rst  = 1'b0;
                obst_en     = 1'b1;
                player_jump = jump_sync;
                // a collision on a tick cycle takes priority over scoring
                if (coll_q) begin
                    hit          = 1'b1;
                    obst_respawn = 1'b1;
                    lives_dec    = 1'b1;
                    if (lives_q == 2'd1) begin
                        state_next = OVER;
                    end else begin
                        state_next  = HIT;
                        freeze_load = 1'b1;
                    end
                end else if (tick_1ms) begin
                    score_inc = 1'b1;
                end
            end
            HIT: begin
                if (tick_1ms) begin
                    freeze_dec = 1'b1;
                    if (freeze == FW'(1))
                        state_next = RUN;
                end
            end
            OVER: begin
                if (start_pulse)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state;
endmodule
